// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame fetch path: FSM encoding and bus widths.
package vga_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_DATA  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/vga_vsync_sync.sv
// Brings the asynchronous VGA vsync into the sdram_clk domain and emits a
// registered one-cycle frame_start pulse on each inactive-to-active transition.
module vga_vsync_sync #(
  parameter logic vs_polarity = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic frame_start_o
);

  logic meta_q;
  logic sync_q;
  logic edge_q;
  logic start_q;

  // Two-flop synchronizer, edge history flop and registered start pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= ~vs_polarity;
      sync_q  <= ~vs_polarity;
      edge_q  <= ~vs_polarity;
      start_q <= 1'b0;
    end else begin
      meta_q  <= vsync_i;
      sync_q  <= meta_q;
      edge_q  <= sync_q;
      start_q <= (sync_q == vs_polarity) && (edge_q != vs_polarity);
    end
  end

  assign frame_start_o = start_q;

endmodule

// File: rtl/vga_frame_fetcher.sv
// Fetches one frame from SDRAM in fixed-length bursts and streams the words
// into the vga_writer FIFO, throttled by the FIFO fill level.
module vga_frame_fetcher
  import vga_pkg::*;
#(
  parameter logic [ADDR_W-1:0] frame_base     = 22'd0,
  parameter logic [ADDR_W-1:0] frame_words    = 22'd224000,
  parameter logic [3:0]        burst_len      = 4'd8,
  parameter logic [7:0]        fifo_threshold = 8'd200,
  parameter logic              vs_polarity    = 1'b0
) (
  input  logic              sdram_clk,
  input  logic              reset,
  input  logic              vsync_in,
  input  logic [7:0]        wrusedw,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_fifo,
  output logic [DATA_W-1:0] sdram_data,
  output logic              busy,
  output logic              frame_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [3:0]        beats_q, beats_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              restart_q, restart_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              frame_start_s;
  logic [3:0]        beat_next_s;
  logic [ADDR_W-1:0] word_next_s;
  logic              burst_done_s;
  logic              frame_done_s;

  vga_vsync_sync #(
    .vs_polarity (vs_polarity)
  ) u_vsync_sync (
    .clk_i         (sdram_clk),
    .rst_ni        (reset),
    .vsync_i       (vsync_in),
    .frame_start_o (frame_start_s)
  );

  assign beat_next_s  = beats_q + 4'd1;
  assign word_next_s  = words_q + 22'd1;
  assign burst_done_s = rd_valid && (beat_next_s == burst_len);
  assign frame_done_s = (word_next_s == frame_words);

  // Next-state logic for the fetch FSM, counters and FIFO write path.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    words_d   = words_q;
    beats_d   = beats_q;
    busy_d    = busy_q;
    err_d     = err_q;
    restart_d = restart_q;
    req_d     = req_q;
    wr_d      = 1'b0;
    data_d    = rd_data;

    case (state_q)
      ST_IDLE: begin
        if (frame_start_s) begin
          addr_d  = frame_base;
          words_d = 22'd0;
          busy_d  = 1'b1;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CHECK: begin
        if (frame_start_s) begin
          addr_d  = frame_base;
          words_d = 22'd0;
          err_d   = 1'b1;
        end else if (wrusedw < fifo_threshold) begin
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_REQ: begin
        // A burst cannot be withdrawn, so a new frame only marks the restart.
        if (frame_start_s) begin
          err_d     = 1'b1;
          restart_d = 1'b1;
        end else begin
          restart_d = restart_q;
        end
        if (rd_ack) begin
          req_d   = 1'b0;
          beats_d = 4'd0;
          state_d = ST_DATA;
        end else begin
          req_d   = 1'b1;
        end
      end

      ST_DATA: begin
        if (rd_valid) begin
          wr_d    = 1'b1;
          beats_d = beat_next_s;
          words_d = word_next_s;
        end else begin
          wr_d    = 1'b0;
        end
        if (burst_done_s) begin
          addr_d = addr_q + ADDR_W'(burst_len);
          if (restart_q || frame_start_s) begin
            // A start coinciding with the last word of the frame is on time.
            addr_d    = frame_base;
            words_d   = 22'd0;
            restart_d = 1'b0;
            err_d     = err_q | (frame_start_s & ~frame_done_s);
            state_d   = ST_CHECK;
          end else if (frame_done_s) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CHECK;
          end
        end else if (frame_start_s) begin
          err_d     = 1'b1;
          restart_d = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge sdram_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= frame_base;
      words_q   <= 22'd0;
      beats_q   <= 4'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      restart_q <= 1'b0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      beats_q   <= beats_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      restart_q <= restart_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
    end
  end

  assign rd_req     = req_q;
  assign rd_addr    = addr_q;
  assign wr_fifo    = wr_q;
  assign sdram_data = data_q;
  assign busy       = busy_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_vga_frame_fetcher.sv
// Directed bench for vga_frame_fetcher: 32-word frames in 8-word bursts with a
// behavioural SDRAM controller and a monitor that logs requests and FIFO writes.
module tb_vga_frame_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync_in;
  logic [7:0]  wrusedw;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_fifo;
  logic [15:0] sdram_data;
  logic        busy;
  logic        frame_err;

  logic        ctl_valid;
  logic        poke_valid;
  int          ack_delay;

  int          checks = 0;
  int          errors = 0;

  int          req_count = 0;
  int          wr_count  = 0;
  int          stab_err  = 0;
  int          drop_err  = 0;
  int          lat_err   = 0;
  logic [21:0] addr_log [64];
  int          hi_log   [64];

  assign rd_valid = ctl_valid | poke_valid;

  always #5 clk = ~clk;

  vga_frame_fetcher #(
    .frame_base     (22'd0),
    .frame_words    (22'd32),
    .burst_len      (4'd8),
    .fifo_threshold (8'd200),
    .vs_polarity    (1'b0)
  ) dut (
    .sdram_clk  (clk),
    .reset      (reset),
    .vsync_in   (vsync_in),
    .wrusedw    (wrusedw),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_fifo    (wr_fifo),
    .sdram_data (sdram_data),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    cyc(6);
    vsync_in = 1'b1;
  endtask

  // Behavioural SDRAM controller: acks after ack_delay cycles, then 8 beats.
  initial begin
    rd_ack    = 1'b0;
    ctl_valid = 1'b0;
    rd_data   = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (rd_req) begin
        repeat (ack_delay) begin
          @(posedge clk);
          #1;
        end
        rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
          ctl_valid = 1'b1;
          rd_data   = rd_data + 16'h0001;
          @(posedge clk);
          #1;
        end
        ctl_valid = 1'b0;
      end
    end
  end

  // Monitor sampled on the falling edge.
  initial begin
    logic        prev_req, prev_ack, prev_valid;
    logic [21:0] prev_addr;
    logic [15:0] prev_data;
    int          hi_run;
    prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0;
    prev_addr = 22'd0; prev_data = 16'd0; hi_run = 0;
    forever begin
      @(negedge clk);
      if (rd_req && !prev_req) begin
        if (req_count < 64) addr_log[req_count] = rd_addr;
        req_count++;
        hi_run = 1;
      end else if (rd_req) begin
        hi_run++;
        if (rd_addr != prev_addr) stab_err++;
      end else if (prev_req) begin
        if (req_count <= 64) hi_log[req_count-1] = hi_run;
        if (!prev_ack && reset) drop_err++;
      end
      if (wr_fifo) begin
        wr_count++;
        if (!prev_valid || sdram_data != prev_data) lat_err++;
      end
      prev_req   = rd_req;
      prev_ack   = rd_ack;
      prev_valid = rd_valid;
      prev_addr  = rd_addr;
      prev_data  = rd_data;
    end
  end

  initial begin
    int  rq0, wr0, n;
    bit  ok;
    reset      = 1'b0;
    vsync_in   = 1'b1;
    wrusedw    = 8'd0;
    poke_valid = 1'b0;
    ack_delay  = 2;
    cyc(4);

    // Reset values
    check_val("rst_rd_req", rd_req, 0);
    check_val("rst_rd_addr", rd_addr, 0);
    check_val("rst_wr_fifo", wr_fifo, 0);
    check_val("rst_sdram_data", sdram_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    cyc(3);

    // Full frame, 4 bursts of 8 words
    rq0 = req_count; wr0 = wr_count;
    vsync_pulse();
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (!busy && wr_count - wr0 > 0) begin ok = 1; break; end
      cyc(1);
    end
    check_val("t1_done_timeout", ok, 1);
    cyc(2);
    check_val("t1_wr_count", wr_count - wr0, 32);
    check_val("t1_req_count", req_count - rq0, 4);
    for (int b = 0; b < 4; b++) check_val("t1_burst_addr", addr_log[rq0+b], b * 8);
    check_val("t1_req_hi_len", hi_log[rq0], 3);
    check_val("t1_frame_err", frame_err, 0);

    // rd_valid while idle must not write
    wr0 = wr_count;
    for (int i = 0; i < 4; i++) begin
      poke_valid = 1'b1;
      cyc(1);
    end
    poke_valid = 1'b0;
    cyc(2);
    check_val("t5_idle_writes", wr_count - wr0, 0);

    // Threshold hold and slow ack
    rq0 = req_count; wr0 = wr_count;
    wrusedw   = 8'd200;
    ack_delay = 10;
    vsync_pulse();
    cyc(30);
    check_val("t2_busy_held", busy, 1);
    check_val("t2_no_req_at_200", req_count - rq0, 0);
    wrusedw = 8'd199;
    ok = 0; n = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_req) begin ok = 1; break; end
      n++;
      cyc(1);
    end
    check_val("t2_req_rise", ok, 1);
    check_val("t2_req_rise_cycles", n, 1);
    ok = 0;
    for (int i = 0; i < 800; i++) begin
      if (!busy) begin ok = 1; break; end
      cyc(1);
    end
    check_val("t3_done_timeout", ok, 1);
    cyc(2);
    check_val("t3_req_hi_len", hi_log[rq0], 11);
    check_val("t3_req_count", req_count - rq0, 4);
    check_val("t3_wr_count", wr_count - wr0, 32);

    // Vsync during DATA of burst 2
    wrusedw   = 8'd0;
    ack_delay = 2;
    rq0 = req_count; wr0 = wr_count;
    vsync_pulse();
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (wr_count - wr0 >= 9) begin ok = 1; break; end
      cyc(1);
    end
    check_val("t4_burst2_timeout", ok, 1);
    vsync_pulse();
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (req_count - rq0 >= 3) begin ok = 1; break; end
      cyc(1);
    end
    check_val("t4_restart_timeout", ok, 1);
    check_val("t4_restart_addr", addr_log[rq0+2], 0);
    check_val("t4_burst2_writes", wr_count - wr0, 16);
    check_val("t4_frame_err", frame_err, 1);
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (!busy) begin ok = 1; break; end
      cyc(1);
    end
    check_val("t4_done_timeout", ok, 1);
    cyc(2);
    check_val("t4_total_writes", wr_count - wr0, 48);
    check_val("t4_err_sticky", frame_err, 1);

    // Reset asserted mid-burst
    rq0 = req_count; wr0 = wr_count;
    vsync_pulse();
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (wr_count - wr0 >= 10) begin ok = 1; break; end
      cyc(1);
    end
    check_val("t6_burst2_timeout", ok, 1);
    check_val("t6_pre_rst_addr", rd_addr, 8);
    check_val("t6_pre_rst_busy", busy, 1);
    reset = 1'b0;
    #2;
    check_val("t6_rst_rd_req", rd_req, 0);
    check_val("t6_rst_rd_addr", rd_addr, 0);
    check_val("t6_rst_wr_fifo", wr_fifo, 0);
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_frame_err", frame_err, 0);
    wr0 = wr_count;
    cyc(12);
    check_val("t6_writes_in_rst", wr_count - wr0, 0);
    reset = 1'b1;
    cyc(3);
    rq0 = req_count; wr0 = wr_count;
    vsync_pulse();
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (!busy && wr_count - wr0 > 0) begin ok = 1; break; end
      cyc(1);
    end
    check_val("t6_done_timeout", ok, 1);
    cyc(2);
    check_val("t6_first_addr", addr_log[rq0], 0);
    check_val("t6_wr_count", wr_count - wr0, 32);
    check_val("t6_frame_err", frame_err, 0);

    // Protocol health across the whole run
    check_val("addr_stable", stab_err, 0);
    check_val("req_drop_no_ack", drop_err, 0);
    check_val("wr_latency", lat_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
